// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes, baud constants and parity helper.
package uart_pkg;

    // Receiver/transmitter state encoding
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    typedef enum logic [1:0] {
        ParNone,
        ParEven,
        ParOdd
    } parity_e;

    // Widest word the parity helper accepts; narrower words are zero-extended
    localparam int unsigned MaxWordLen = 32;

    // Clocks per bit (integer division)
    function automatic int unsigned baud_div(input int unsigned clk_rate, input int unsigned baud);
        return clk_rate / baud;
    endfunction

    // Clocks from the start-bit edge to the start-bit centre
    function automatic int unsigned half_bit(input int unsigned clk_rate, input int unsigned baud);
        return baud_div(clk_rate, baud) / 2;
    endfunction

    // Expected parity bit for a word; zero-extension does not change the XOR
    function automatic logic par(input logic [MaxWordLen-1:0] word, input parity_e mode);
        logic p;
        case (mode)
            ParEven: p = ^word;
            ParOdd:  p = ~^word;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable preset value.
module uart_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops; reset presets both to ResetVal
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{ResetVal}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first word assembly, parity/frame/overrun flags,
// and a single-entry valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned clk_rate = 50_000_000,
    parameter int unsigned Baud     = 115200,
    parameter int unsigned Word_len = 8,
    parameter string       PARITY   = "even"
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Uart_rx,
    output logic [Word_len-1:0] rx_data,
    output logic                rx_data_valid,
    input  logic                rx_data_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err
);

    localparam int unsigned BaudDiv = baud_div(clk_rate, Baud);
    localparam int unsigned HalfBit = half_bit(clk_rate, Baud);
    localparam int unsigned CntW    = $clog2(BaudDiv);
    localparam int unsigned BitW    = $clog2(Word_len + 1);

    localparam logic [CntW-1:0] CntFull = CntW'(BaudDiv - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(Word_len - 1);

    localparam parity_e ParMode = (PARITY == "none") ? ParNone :
                                  (PARITY == "odd")  ? ParOdd  : ParEven;

    logic                rx_s;
    logic                rx_prev_q;
    uart_state_e         state_q;
    logic [CntW-1:0]     baud_cnt_q;
    logic [BitW-1:0]     bit_cnt_q;
    logic [Word_len-1:0] shift_q;
    logic                par_bad_q;

    logic bit_tick;
    logic half_tick;
    logic frame_done;
    logic retire;

    logic [Word_len-1:0] rx_data_d, rx_data_q;
    logic                valid_d, valid_q;
    logic                perr_d, perr_q;
    logic                ferr_d, ferr_q;
    logic                ovr_d, ovr_q;

    uart_sync2 #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (Uart_rx),
        .q_o   (rx_s)
    );

    assign bit_tick   = (baud_cnt_q == CntFull);
    assign half_tick  = (baud_cnt_q == CntHalf);
    assign frame_done = (state_q == StStop) && bit_tick;
    assign retire     = valid_q && rx_data_ready;

    // Receive FSM with baud/bit counters, shift register and parity result.
    // Start detection needs a 1->0 edge of rx_s, so after a break (stop sampled low)
    // nothing re-arms until the line has returned high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            unique case (state_q)
                StIdle: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q    <= StStart;
                        baud_cnt_q <= '0;
                    end
                end
                StStart: begin
                    if (half_tick) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        par_bad_q  <= 1'b0;
                        // A start bit that is high again at its centre was a glitch
                        state_q    <= rx_s ? StIdle : StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rx_s, shift_q[Word_len-1:1]};
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_q <= '0;
                            state_q   <= (ParMode == ParNone) ? StStop : StParity;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        par_bad_q  <= (rx_s != par(MaxWordLen'(shift_q), ParMode));
                        state_q    <= StStop;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        state_q    <= StIdle;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output register next state: retire on handshake, load or drop on frame completion
    always_comb begin
        rx_data_d = rx_data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        if (retire) begin
            valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!valid_q || retire) begin
                rx_data_d = shift_q;
                perr_d    = par_bad_q;
                ferr_d    = ~rx_s;
                valid_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Output register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = valid_q;
    assign parity_err    = perr_q;
    assign frame_err     = ferr_q;
    assign overrun_err   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: behavioural serial transmitter, timed scoreboard of the single-entry
// output register, per-cycle compare, plus literal expectations for each directed frame.
module tb_uart_rx;

    localparam int unsigned ClkRate  = 50_000_000;
    localparam int unsigned BaudRate = 115200;
    localparam int unsigned W        = 8;
    localparam int unsigned Div      = ClkRate / BaudRate;   // 434 clocks per bit
    localparam int unsigned Half     = Div / 2;              // 217
    // Word visible one clock after the stop-bit centre, plus two synchronizer clocks and
    // one edge-detect clock: 3 + 217 + 10*434 = 4560 clocks after the start edge is driven.
    localparam int unsigned Lat      = 3 + Half + (1 + W + 1) * Div;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         uart_line = 1'b1;
    logic         ready = 1'b1;
    logic [W-1:0] rx_data;
    logic         valid;
    logic         perr;
    logic         ferr;
    logic         ovr;

    uart_rx #(
        .clk_rate(ClkRate),
        .Baud    (BaudRate),
        .Word_len(W),
        .PARITY  ("even")
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Uart_rx      (uart_line),
        .rx_data      (rx_data),
        .rx_data_valid(valid),
        .rx_data_ready(ready),
        .parity_err   (perr),
        .frame_err    (ferr),
        .overrun_err  (ovr)
    );

    always #10 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    typedef struct {
        logic [W-1:0] data;
        bit           perr;
        bit           ferr;
        int unsigned  done;
    } frame_t;

    frame_t pend[$];

    bit           m_valid = 1'b0;
    bit           m_ovr   = 1'b0;
    bit           m_perr  = 1'b0;
    bit           m_ferr  = 1'b0;
    logic [W-1:0] m_data  = '0;
    bit           m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural transmitter; records the frame it is about to send in the scoreboard
    task automatic send_frame(input logic [W-1:0] d, input bit flip_par, input bit stop_val);
        frame_t      f;
        logic [10:0] bits;
        @(negedge clk);
        f.data = d;
        f.perr = flip_par;
        f.ferr = ~stop_val;
        f.done = cyc + Lat;
        pend.push_back(f);
        bits = {stop_val, (^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_line = bits[i];
            repeat (Div) @(negedge clk);
        end
    endtask

    task automatic wait_word(input string name, input logic [W-1:0] d, input bit pe, input bit fe);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < int'(Lat + Div));
        if (!valid) begin
            total++;
            bad++;
            $display("FAIL %s: no word within %0d cycles, want data %h", name, n, d);
        end else begin
            chk({name, "_data"}, 32'(rx_data), 32'(d));
            chk({name, "_perr"}, 32'(perr), 32'(pe));
            chk({name, "_ferr"}, 32'(ferr), 32'(fe));
        end
    endtask

    // Scoreboard model of the held word: frames complete at their due cycle
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            pend.delete();
        end else begin
            m_ret = m_valid && ready;
            if (m_ret) m_valid = 1'b0;
            if (pend.size() > 0 && pend[0].done == cyc) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_data  = pend[0].data;
                    m_perr  = pend[0].perr;
                    m_ferr  = pend[0].ferr;
                end else begin
                    m_ovr = 1'b1;
                end
                void'(pend.pop_front());
            end
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("reset_outputs", {20'b0, valid, ovr, perr, ferr, rx_data}, 32'd0);
        end else begin
            chk("valid_overrun", {30'b0, valid, ovr}, {30'b0, m_valid, m_ovr});
            if (m_valid) begin
                chk("held_word", {22'b0, perr, ferr, rx_data}, {22'b0, m_perr, m_ferr, m_data});
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_flags", {29'b0, perr, ferr, ovr}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Clean even-parity frame, valid for exactly one cycle with ready high
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                wait_word("a5", 8'hA5, 1'b0, 1'b0);
                @(negedge clk);
                chk("a5_one_cycle", 32'(valid), 32'd0);
            end
        join
        repeat (20) @(negedge clk);

        // Wrong parity bit
        fork
            send_frame(8'h3C, 1'b1, 1'b1);
            wait_word("3c", 8'h3C, 1'b1, 1'b0);
        join
        repeat (20) @(negedge clk);

        // Stop bit low, then the line stays low for 20 bit-times
        fork
            send_frame(8'h55, 1'b0, 1'b0);
            wait_word("55", 8'h55, 1'b0, 1'b1);
        join
        repeat (20 * Div) @(negedge clk);
        chk("break_quiet", 32'(valid), 32'd0);
        uart_line = 1'b1;
        repeat (2 * Div) @(negedge clk);

        // Short low glitch in idle emits nothing
        uart_line = 1'b0;
        repeat (100) @(negedge clk);
        uart_line = 1'b1;
        repeat (Div) @(negedge clk);
        chk("glitch_quiet", 32'(valid), 32'd0);
        fork
            send_frame(8'h81, 1'b0, 1'b1);
            wait_word("81", 8'h81, 1'b0, 1'b0);
        join
        repeat (20) @(negedge clk);

        // Back-pressure: second word is dropped and overrun sticks
        ready = 1'b0;
        fork
            send_frame(8'h11, 1'b0, 1'b1);
            wait_word("ovr_first", 8'h11, 1'b0, 1'b0);
        join
        send_frame(8'h22, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("ovr_hold_data", 32'(rx_data), 32'h11);
        chk("ovr_hold_valid", 32'(valid), 32'd1);
        chk("ovr_flag", 32'(ovr), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        chk("ovr_retired", 32'(valid), 32'd0);
        chk("ovr_sticky", 32'(ovr), 32'd1);
        repeat (20) @(negedge clk);

        // Reset in the middle of the data bits; held until the frame has ended
        fork
            send_frame(8'hF0, 1'b0, 1'b1);
            begin
                repeat (4 * Div) @(negedge clk);
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                chk("midreset_data", 32'(rx_data), 32'd0);
                chk("midreset_flags", {29'b0, valid, ovr, ferr}, 32'd0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        // Back-to-back frames after reset
        fork
            begin
                send_frame(8'h0F, 1'b0, 1'b1);
                send_frame(8'h97, 1'b0, 1'b1);
            end
            begin
                wait_word("b2b_0f", 8'h0F, 1'b0, 1'b0);
                wait_word("b2b_97", 8'h97, 1'b0, 1'b0);
            end
        join
        repeat (100) @(negedge clk);
        chk("final_ovr", 32'(ovr), 32'd0);
        chk("final_valid", 32'(valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
